inst_bus_if: RTL and testbench
==============================

# inst_bus_if

Instruction-fetch bus interface: the responder end of the fetch request (`pc`/`ce`) issued by the PC register. It turns each enabled fetch address into a Wishbone-classic read, and asserts a stall request to the pipeline controller until the instruction word is returned. It holds the returned word while the IF stage is stalled, and aborts cleanly on branch flush, bus error, misalignment or timeout. It sits between the PC register / IF-ID latch and the external instruction bus.

## Interface
- `TIMEOUT`, 255: max cycles in BUSY without `ack`/`err` before abort; 0 disables the timeout.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_i`  in  32  fetch address from the PC register.
- `ce_i`  in  1  fetch enable from the PC register; 0 means no request.
- `stall_i`  in  6  pipeline stall vector from the controller; bit 1 = IF stage stalled.
- `flush_i`  in  1  branch/exception flush; abandons any in-flight fetch.
- `inst_o`  out  32  instruction to the IF/ID latch; 32'h0 (NOP) when not valid.
- `stallreq_o`  out  1  request to the controller to stall the pipeline.
- `fetch_err_o`  out  1  one-cycle pulse on misaligned PC, bus error or timeout.
- `wb_adr_o`  out  32  bus address.
- `wb_dat_i`  in  32  bus read data.
- `wb_cyc_o`, `wb_stb_o`  out  1  cycle/strobe, always driven equal.
- `wb_we_o`  out  1  constant 0.
- `wb_sel_o`  out  4  constant 4'hF.
- `wb_ack_i`, `wb_err_i`  in  1  slave acknowledge / error.

## Operation
- Reset values:
  - state = IDLE, `wb_cyc_o` = `wb_stb_o` = 0.
  - `wb_adr_o` = 0, hold buffer = 0, timeout counter = 0.
  - `fetch_err_o` = 0, `inst_o` = 0, `stallreq_o` = 0.
- Reset mid-transaction drops `cyc`/`stb` on the next edge with no error pulse.
- IDLE:
  - `ce_i` = 1, `flush_i` = 0, `pc_i[1:0]` = 0: register `adr` ← `pc_i`, `cyc`/`stb` ← 1, clear counter, go to BUSY. `stallreq_o` = 1 combinationally this cycle.
  - `ce_i` = 1 with `pc_i[1:0]` ≠ 0: no bus cycle, `fetch_err_o` pulses next cycle, stay in IDLE, `stallreq_o` = 0.
  - Otherwise stay in IDLE, `stallreq_o` = 0.
- BUSY:
  - `flush_i` = 1 (highest priority, even if `ack` arrives the same cycle): drop `cyc`/`stb`, discard data, go to IDLE, `stallreq_o` = 0, `inst_o` = 0.
  - `wb_ack_i` = 1: `inst_o` = `wb_dat_i` combinationally, `stallreq_o` = 0, drop `cyc`/`stb`, capture the word into the hold buffer. Go to WAIT_FOR_STALL if `stall_i[1]` = 1, else IDLE.
  - `wb_err_i` = 1 (also wins over a simultaneous `ack`): drop `cyc`/`stb`, `inst_o` = 0, `stallreq_o` = 0, `fetch_err_o` pulses next cycle, go to IDLE.
  - Counter reaches `TIMEOUT`: same as the `err` case.
  - Otherwise `stallreq_o` = 1, `inst_o` = 0, counter += 1 (saturating).
- WAIT_FOR_STALL:
  - `inst_o` = hold buffer, `stallreq_o` = 0.
  - Leave to IDLE when `stall_i[1]` = 0 or `flush_i` = 1.
- `adr` is stable for the whole BUSY period; `pc_i` changes during BUSY are ignored.

## Timing
- Minimum fetch latency is 2 cycles:
  - cycle N: IDLE sees the request, `stallreq_o` = 1.
  - cycle N+1: `cyc`/`stb` high; a zero-wait slave acks, so `inst_o` is valid and `stallreq_o` = 0.
- Each slave wait state adds one cycle of `stallreq_o` = 1.
- Back-to-back fetches: the next request is accepted in the IDLE cycle after an ack, so sustained throughput is 1 instruction per 2 cycles.
- `fetch_err_o` is registered: exactly one cycle high, the cycle after detection.
- Timeout fires on the cycle where the count equals `TIMEOUT`, i.e. after `TIMEOUT` BUSY cycles without a response.

## Structure
- The shared `de.v` holds:
  - state encodings `IFB_IDLE`, `IFB_BUSY`, `IFB_WAIT_FOR_STALL`;
  - `ZeroWord` / NOP;
  - `RstEnable`, `Stop`, `NotStop`;
  - `WbSelAll` (4'hF).
- One sub-module, `wb_timeout_cnt`: a saturating counter with clear, enable and an equals-limit flag, parameterised by `TIMEOUT`. Everything else stays in `inst_bus_if`.

## Test plan
- Zero-wait slave, `pc_i` = 0x0 then 0x4, `ce_i` = 1, no stall:
  - `wb_adr_o` = 0x0 at N+1 with `inst_o` = mem[0];
  - `wb_adr_o` = 0x4 at N+3 with `inst_o` = mem[1];
  - `stallreq_o` pattern 1,0,1,0.
- Slave with 3 wait states: `stallreq_o` high for 4 cycles, `cyc` held with stable address, `inst_o` = 0x3C010001 on the ack cycle only.
- Ack while `stall_i[1]` = 1 for 3 cycles: `inst_o` holds 0x3C010001 through WAIT_FOR_STALL, then IDLE; no new bus cycle until the stall releases.
- `flush_i` asserted in the same cycle as `ack`: `inst_o` = 0, `cyc` drops, IDLE. The next request, `pc_i` = 0x100, produces `adr` = 0x100.
- `pc_i` = 0x2: no `cyc`, one-cycle `fetch_err_o`.
- `wb_err_i` mid-BUSY: `cyc` drops, `fetch_err_o` pulses once.
- `TIMEOUT` = 4 with a silent slave: abort after 4 BUSY cycles, `fetch_err_o` pulse.
- `rst` during BUSY: the next cycle shows all outputs 0 and the state in IDLE.

Source files
------------

// File: rtl/inst_bus_if_pkg.sv
// -----------------------------------------------------------------------------
// inst_bus_if_pkg
// Shared definitions for the instruction-fetch bus interface: the fetch FSM
// state encoding, the NOP word, reset/stall polarity constants and the
// Wishbone byte-select value used for full-word reads.
// -----------------------------------------------------------------------------
package inst_bus_if_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      IFB_IDLE           = 2'd0,
      IFB_BUSY           = 2'd1,
      IFB_WAIT_FOR_STALL = 2'd2
   } ifb_state_t;

   // NOP / empty instruction word
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;

   // Reset is active high
   localparam logic        RstEnable = 1'b1;

   // Stall request / stall vector polarity
   localparam logic        Stop      = 1'b1;
   localparam logic        NotStop   = 1'b0;

   // All four byte lanes: instruction fetches are always full words
   localparam logic [3:0]  WbSelAll  = 4'hF;

endpackage

// File: rtl/inst_bus_if_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Saturating cycle counter used to bound how long a fetch waits for the bus.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_clear    zero the count (wins over i_enable)
//   i_enable   advance the count by one, saturating at all-ones
//   o_atLimit  count equals TIMEOUT; never asserted when TIMEOUT is 0
// -----------------------------------------------------------------------------
module wb_timeout_cnt
   import inst_bus_if_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_atLimit
);

   // Wide enough to hold TIMEOUT itself, and at least one bit when TIMEOUT is 0
   localparam int CntW = $clog2(TIMEOUT + 2);

   logic [CntW-1:0] r_count;

   // Count up while enabled; holding at all-ones keeps the count from
   // wrapping back below the limit if the enable is left on.
   always_ff @(posedge i_clk) begin
      if (i_rst == RstEnable) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != {CntW{1'b1}})) begin
         r_count <= r_count + CntW'(1);
      end
   end

   // A zero TIMEOUT turns the limit flag off entirely
   assign o_atLimit = (TIMEOUT != 0) && (r_count == CntW'(TIMEOUT));

endmodule

// File: rtl/inst_bus_if.sv
// -----------------------------------------------------------------------------
// inst_bus_if
// Instruction-fetch bus interface. Turns each enabled, word-aligned fetch
// address into a Wishbone-classic read, stalls the pipeline until the word
// returns, holds the word while IF is stalled and aborts on flush, bus error,
// misalignment or timeout.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   pc_i, ce_i      fetch address and enable from the PC register
//   stall_i         pipeline stall vector (bit 1 = IF stalled)
//   flush_i         abandon any in-flight fetch
//   inst_o          instruction to IF/ID (NOP when nothing valid)
//   stallreq_o      stall request to the pipeline controller
//   fetch_err_o     one-cycle pulse after misalignment, bus error or timeout
//   wb_*            Wishbone-classic master read port
// -----------------------------------------------------------------------------
module inst_bus_if
   import inst_bus_if_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        ce_i,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   output logic [31:0] inst_o,
   output logic        stallreq_o,
   output logic        fetch_err_o,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   ifb_state_t  r_state;
   ifb_state_t  w_nextState;
   logic [31:0] r_adr;
   logic        r_cyc;
   logic [31:0] r_hold;
   logic        r_fetchErr;

   logic        w_launch;
   logic        w_drop;
   logic        w_capture;
   logic        w_errNext;
   logic        w_cntClear;
   logic        w_cntEn;
   logic        w_timeout;
   logic [31:0] w_inst;
   logic        w_stallreq;
   logic        w_unusedStall;

   // Only the IF bit of the stall vector matters to this stage
   assign w_unusedStall = ^{stall_i[5:2], stall_i[0]};

   // Counts BUSY cycles without a response; cleared whenever a fetch launches
   wb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_clear   (w_cntClear),
      .i_enable  (w_cntEn),
      .o_atLimit (w_timeout)
   );

   // Next-state and combinational outputs. Inside BUSY the priority is
   // flush > bus error > ack > timeout, so a flush or error arriving with an
   // ack throws the data away. While reset is held the combinational
   // outputs are forced quiet so the pipeline sees no stale request.
   always_comb begin
      w_nextState = r_state;
      w_launch    = 1'b0;
      w_drop      = 1'b0;
      w_capture   = 1'b0;
      w_errNext   = 1'b0;
      w_cntClear  = 1'b0;
      w_cntEn     = 1'b0;
      w_inst      = ZeroWord;
      w_stallreq  = NotStop;

      case (r_state)
         IFB_IDLE: begin
            if (ce_i) begin
               if (pc_i[1:0] != 2'b00) begin
                  w_errNext = 1'b1;
               end else if (!flush_i) begin
                  w_launch    = 1'b1;
                  w_cntClear  = 1'b1;
                  w_stallreq  = Stop;
                  w_nextState = IFB_BUSY;
               end
            end
         end

         IFB_BUSY: begin
            if (flush_i) begin
               w_drop      = 1'b1;
               w_nextState = IFB_IDLE;
            end else if (wb_err_i) begin
               w_drop      = 1'b1;
               w_errNext   = 1'b1;
               w_nextState = IFB_IDLE;
            end else if (wb_ack_i) begin
               w_drop      = 1'b1;
               w_capture   = 1'b1;
               w_inst      = wb_dat_i;
               w_nextState = (stall_i[1] == Stop) ? IFB_WAIT_FOR_STALL : IFB_IDLE;
            end else if (w_timeout) begin
               w_drop      = 1'b1;
               w_errNext   = 1'b1;
               w_nextState = IFB_IDLE;
            end else begin
               w_stallreq = Stop;
               w_cntEn    = 1'b1;
            end
         end

         IFB_WAIT_FOR_STALL: begin
            w_inst = r_hold;
            if ((stall_i[1] != Stop) || flush_i) begin
               w_nextState = IFB_IDLE;
            end
         end

         default: begin
            w_nextState = IFB_IDLE;
         end
      endcase

      if (rst == RstEnable) begin
         w_inst     = ZeroWord;
         w_stallreq = NotStop;
      end
   end

   // State, bus-cycle and hold registers. The address is only loaded on
   // launch so it stays stable for the whole BUSY period.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_state    <= IFB_IDLE;
         r_adr      <= ZeroWord;
         r_cyc      <= 1'b0;
         r_hold     <= ZeroWord;
         r_fetchErr <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_fetchErr <= w_errNext;
         if (w_launch) begin
            r_adr <= pc_i;
            r_cyc <= 1'b1;
         end else if (w_drop) begin
            r_cyc <= 1'b0;
         end
         if (w_capture) begin
            r_hold <= wb_dat_i;
         end
      end
   end

   assign inst_o      = w_inst;
   assign stallreq_o  = w_stallreq;
   assign fetch_err_o = r_fetchErr;
   assign wb_adr_o    = r_adr;
   assign wb_cyc_o    = r_cyc;
   assign wb_stb_o    = r_cyc;
   assign wb_we_o     = 1'b0;
   assign wb_sel_o    = WbSelAll;

endmodule

// File: tb/tb_inst_bus_if.sv
// -----------------------------------------------------------------------------
// tb_inst_bus_if
// Directed per-cycle vectors for inst_bus_if. Each vector drives the inputs
// for one cycle and queues the hand-computed outputs for that cycle; a
// separate monitor pops and compares them mid-cycle.
// -----------------------------------------------------------------------------
module tb_inst_bus_if;

   localparam int TO = 4;
   localparam logic [31:0] M0 = 32'h3C01_0001;
   localparam logic [31:0] M1 = 32'h3421_0002;

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic        sreq;
      logic        ferr;
      logic        cyc;
      logic [31:0] adr;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic [31:0] inst_o;
   logic        stallreq_o;
   logic        fetch_err_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_i;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;
   logic        wb_err_i;

   exp_t expQ[$];
   int   vectors;
   int   miscompares;

   inst_bus_if #(
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_i        (pc_i),
      .ce_i        (ce_i),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .inst_o      (inst_o),
      .stallreq_o  (stallreq_o),
      .fetch_err_o (fetch_err_o),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_i    (wb_dat_i),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_sel_o    (wb_sel_o),
      .wb_ack_i    (wb_ack_i),
      .wb_err_i    (wb_err_i)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one output field and log a miscompare
   task automatic checkOutput(input string vec, input string field,
                              input logic [31:0] actual, input logic [31:0] expected);
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s.%s: got %h, expected %h", vec, field, actual, expected);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue the
   // outputs expected for that same cycle
   task automatic applyStimulus(input string name, input logic r, input logic ce,
                                input logic [31:0] pc, input logic stl, input logic fl,
                                input logic ack, input logic err, input logic [31:0] dat,
                                input logic [31:0] eInst, input logic eSreq,
                                input logic eFerr, input logic eCyc,
                                input logic [31:0] eAdr);
      exp_t e;
      @(posedge clk);
      #1;
      rst      = r;
      ce_i     = ce;
      pc_i     = pc;
      stall_i  = {4'b0000, stl, 1'b0};
      flush_i  = fl;
      wb_ack_i = ack;
      wb_err_i = err;
      wb_dat_i = dat;
      e.name = name;
      e.inst = eInst;
      e.sreq = eSreq;
      e.ferr = eFerr;
      e.cyc  = eCyc;
      e.adr  = eAdr;
      expQ.push_back(e);
   endtask

   // Monitor: on every falling edge, pop the expectation for this cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            vectors++;
            checkOutput(e.name, "inst", inst_o, e.inst);
            checkOutput(e.name, "stallreq", {31'b0, stallreq_o}, {31'b0, e.sreq});
            checkOutput(e.name, "fetch_err", {31'b0, fetch_err_o}, {31'b0, e.ferr});
            checkOutput(e.name, "cyc", {31'b0, wb_cyc_o}, {31'b0, e.cyc});
            checkOutput(e.name, "stb", {31'b0, wb_stb_o}, {31'b0, e.cyc});
            checkOutput(e.name, "adr", wb_adr_o, e.adr);
            checkOutput(e.name, "we", {31'b0, wb_we_o}, 32'h0);
            checkOutput(e.name, "sel", {28'b0, wb_sel_o}, 32'hF);
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst      = 1'b1;
      ce_i     = 1'b0;
      pc_i     = 32'h0;
      stall_i  = 6'b0;
      flush_i  = 1'b0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'h0;

      //              name      rst ce  pc            stl fl  ack err dat            | inst   sreq ferr cyc adr
      applyStimulus("rst0",     1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h0);
      applyStimulus("rst1",     1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h0);
      // Zero-wait back-to-back fetches
      applyStimulus("zw_req0",  0, 1, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h0);
      applyStimulus("zw_ack0",  0, 1, 32'h4,         0, 0, 1, 0, M0,            M0,    0, 0, 1, 32'h0);
      applyStimulus("zw_req1",  0, 1, 32'h4,         0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h0);
      applyStimulus("zw_ack1",  0, 1, 32'h8,         0, 0, 1, 0, M1,            M1,    0, 0, 1, 32'h4);
      applyStimulus("zw_idle",  0, 0, 32'h8,         0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h4);
      // Three wait states, pc changes ignored while busy
      applyStimulus("ws_req",   0, 1, 32'h10,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h4);
      applyStimulus("ws_w1",    0, 0, 32'h10,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 1, 32'h10);
      applyStimulus("ws_w2",    0, 0, 32'h10,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 1, 32'h10);
      applyStimulus("ws_w3",    0, 1, 32'h44,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 1, 32'h10);
      applyStimulus("ws_ack",   0, 0, 32'h44,        0, 0, 1, 0, M0,            M0,    0, 0, 1, 32'h10);
      applyStimulus("ws_after", 0, 0, 32'h44,        0, 0, 0, 0, M0,            32'h0, 0, 0, 0, 32'h10);
      // Ack while IF stalled: word held until stall releases
      applyStimulus("st_req",   0, 1, 32'h20,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h10);
      applyStimulus("st_ack",   0, 1, 32'h20,        1, 0, 1, 0, M0,            M0,    0, 0, 1, 32'h20);
      applyStimulus("st_hold1", 0, 1, 32'h24,        1, 0, 0, 0, 32'h0,         M0,    0, 0, 0, 32'h20);
      applyStimulus("st_hold2", 0, 1, 32'h24,        1, 0, 0, 0, 32'h0,         M0,    0, 0, 0, 32'h20);
      applyStimulus("st_rel",   0, 1, 32'h24,        0, 0, 0, 0, 32'h0,         M0,    0, 0, 0, 32'h20);
      applyStimulus("st_req2",  0, 1, 32'h24,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h20);
      applyStimulus("st_ack2",  0, 0, 32'h24,        0, 0, 1, 0, M1,            M1,    0, 0, 1, 32'h24);
      // Flush on the ack cycle, then a fresh request
      applyStimulus("fl_req",   0, 1, 32'h30,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h24);
      applyStimulus("fl_ack",   0, 1, 32'h30,        0, 1, 1, 0, 32'hDEADBEEF,  32'h0, 0, 0, 1, 32'h30);
      applyStimulus("fl_req2",  0, 1, 32'h100,       0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h30);
      applyStimulus("fl_ack2",  0, 0, 32'h100,       0, 0, 1, 0, M0,            M0,    0, 0, 1, 32'h100);
      // Misaligned pc
      applyStimulus("ma_req",   0, 1, 32'h2,         0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h100);
      applyStimulus("ma_err",   0, 0, 32'h2,         0, 0, 0, 0, 32'h0,         32'h0, 0, 1, 0, 32'h100);
      applyStimulus("ma_end",   0, 0, 32'h2,         0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h100);
      // Bus error mid-BUSY, beating a simultaneous ack
      applyStimulus("be_req",   0, 1, 32'h40,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h100);
      applyStimulus("be_wait",  0, 0, 32'h40,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 1, 32'h40);
      applyStimulus("be_err",   0, 0, 32'h40,        0, 0, 1, 1, 32'h11111111,  32'h0, 0, 0, 1, 32'h40);
      applyStimulus("be_pulse", 0, 0, 32'h40,        0, 0, 0, 0, 32'h0,         32'h0, 0, 1, 0, 32'h40);
      applyStimulus("be_end",   0, 0, 32'h40,        0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h40);
      // Silent slave: abort on the BUSY cycle where the count reaches TO
      applyStimulus("to_req",   0, 1, 32'h50,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h40);
      for (int i = 0; i < TO; i++) begin
         applyStimulus("to_wait", 0, 0, 32'h50,      0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 1, 32'h50);
      end
      applyStimulus("to_abort", 0, 0, 32'h50,        0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 1, 32'h50);
      applyStimulus("to_pulse", 0, 0, 32'h50,        0, 0, 0, 0, 32'h0,         32'h0, 0, 1, 0, 32'h50);
      applyStimulus("to_end",   0, 0, 32'h50,        0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h50);
      // Reset mid-transaction
      applyStimulus("rb_req",   0, 1, 32'h60,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 0, 32'h50);
      applyStimulus("rb_busy",  0, 0, 32'h60,        0, 0, 0, 0, 32'h0,         32'h0, 1, 0, 1, 32'h60);
      applyStimulus("rb_rst",   1, 0, 32'h60,        0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 1, 32'h60);
      applyStimulus("rb_after", 0, 0, 32'h60,        0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h0);
      // Flush in IDLE blocks a new request
      applyStimulus("fi_req",   0, 1, 32'h70,        0, 1, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h0);
      applyStimulus("fi_after", 0, 0, 32'h70,        0, 0, 0, 0, 32'h0,         32'h0, 0, 0, 0, 32'h0);

      // Give the monitor time to drain, bounded
      repeat (3) @(posedge clk);
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
